// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default operand width for the restoring divider
package div_pkg;
    localparam int DIV_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, SHIFT, SUB, DONE} div_state_t;
endpackage

// File: rtl/divider_unit_if.sv
// divider_unit_if: front-end bundle for the divider
//   master drives Run, ClearA_LoadB, Dividend, Divisor
//   slave returns Quotient, Remainder, Busy, Done, DivZero
interface divider_unit_if #(parameter int WIDTH = 8);
    logic             Run;
    logic             ClearA_LoadB;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    modport master (output Run, ClearA_LoadB, Dividend, Divisor,
                    input  Quotient, Remainder, Busy, Done, DivZero);
    modport slave  (input  Run, ClearA_LoadB, Dividend, Divisor,
                    output Quotient, Remainder, Busy, Done, DivZero);
endinterface

// File: rtl/div_datapath.sv
// div_datapath: A/Q/M registers and WIDTH+1-bit trial subtractor
//   Clk, Reset_n           clock, async active-low reset
//   load, clear, shift, sub one-hot step controls from the FSM
//   dividend, divisor      operands captured on load
//   quotient, remainder    Q and low bits of A
//   div_zero               set when load sees a zero divisor
module div_datapath #(parameter int WIDTH = 8) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             load,
    input  logic             clear,
    input  logic             shift,
    input  logic             sub,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   d;
    logic             dz;

    assign dz = divisor == '0;
    assign d  = a - {1'b0, m};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a        <= '0;
            q        <= '0;
            m        <= '0;
            div_zero <= 1'b0;
        end else if (load) begin
            // zero divisor short-circuits to the result a full restoring pass would give
            a        <= dz ? {1'b0, dividend} : '0;
            q        <= dz ? '1 : dividend;
            m        <= divisor;
            div_zero <= dz;
        end else if (clear) begin
            a        <= '0;
            q        <= '0;
            div_zero <= 1'b0;
        end else if (shift) begin
            {a, q} <= {a[WIDTH-1:0], q, 1'b0};
        end else if (sub) begin
            // a negative trial difference restores by simply not writing A
            if (!d[WIDTH])
                a <= d;
            q[0] <= ~d[WIDTH];
        end
    end

    assign quotient  = q;
    assign remainder = a[WIDTH-1:0];
endmodule

// File: rtl/divider_unit.sv
// divider_unit: sequential unsigned restoring divider, one quotient bit per SHIFT/SUB pair
//   Clk, Reset_n  clock, async active-low reset
//   bus           slave side of divider_unit_if (Run/ClearA_LoadB/operands in, results/status out)
module divider_unit import div_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
    input logic             Clk,
    input logic             Reset_n,
    divider_unit_if.slave   bus
);
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    div_state_t    state;
    logic [CW-1:0] cnt;
    logic          load;
    logic          clear;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.Run)
                        state <= (bus.Divisor == '0) ? DONE : SHIFT;
                end
                SHIFT: state <= SUB;
                SUB: begin
                    if (cnt == LAST)
                        state <= DONE;
                    else begin
                        cnt   <= cnt + 1'b1;
                        state <= SHIFT;
                    end
                end
                default: if (!bus.Run) state <= IDLE;
            endcase
        end
    end

    always_comb begin
        load  = state == IDLE && bus.Run;
        clear = state == IDLE && !bus.Run && bus.ClearA_LoadB;
    end

    assign bus.Busy = state == SHIFT || state == SUB;
    assign bus.Done = state == DONE;

    div_datapath #(.WIDTH(WIDTH)) u_dp (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .load      (load),
        .clear     (clear),
        .shift     (state == SHIFT),
        .sub       (state == SUB),
        .dividend  (bus.Dividend),
        .divisor   (bus.Divisor),
        .quotient  (bus.Quotient),
        .remainder (bus.Remainder),
        .div_zero  (bus.DivZero)
    );
endmodule
